// File: rtl/pwm_update_scheduler_if.sv
// Register write bus from the SPI peripheral into the PWM update scheduler.
interface pwm_update_scheduler_if;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_update_scheduler.sv
// Shadows PWM config writes and commits them to live registers 2 cycles after a period tick, force or timeout.
// No backpressure: a write is accepted every cycle, including in the commit cycle.
module pwm_update_scheduler #(
  parameter int MAX_WAIT = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  pwm_update_scheduler_if.slave        wr,
  input  logic                         period_tick,
  output logic [7:0]                   en_reg_out_7_0,
  output logic [7:0]                   en_reg_out_15_8,
  output logic [7:0]                   en_reg_pwm_7_0,
  output logic [7:0]                   en_reg_pwm_15_8,
  output logic [7:0]                   pwm_duty_cycle,
  output logic                         pending,
  output logic                         commit_pulse,
  output logic                         err_addr
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t              state;
  logic [4:0][7:0]     shadow;
  logic [4:0][7:0]     live;
  logic [4:0]          mask;
  logic [CW-1:0]       wait_cnt;

  logic [4:0]          wr_bit;
  logic                force_req;
  logic                err_clr;
  logic                err_set;

  always_comb begin
    wr_bit = '0;
    for (int i = 0; i < 5; i++) begin
      wr_bit[i] = wr.wr_valid && (wr.wr_addr == 7'(i));
    end
    force_req = wr.wr_valid && (wr.wr_addr == 7'd5) && wr.wr_data[0];
    err_clr   = wr.wr_valid && (wr.wr_addr == 7'd5) && wr.wr_data[1];
    err_set   = wr.wr_valid && (wr.wr_addr >= 7'd6);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shadow       <= '0;
      live         <= '0;
      mask         <= '0;
      wait_cnt     <= '0;
      commit_pulse <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wr_bit[i]) shadow[i] <= wr.wr_data;
      end

      if (err_clr)      err_addr <= 1'b0;
      else if (err_set) err_addr <= 1'b1;

      commit_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (|wr_bit) begin
            mask     <= wr_bit;
            wait_cnt <= '0;
            state    <= PENDING;
          end
        end
        PENDING: begin
          mask     <= mask | wr_bit;
          wait_cnt <= wait_cnt + CW'(1);
          if (period_tick || force_req || (wait_cnt == LAST)) state <= COMMIT;
        end
        COMMIT: begin
          // Live takes the pre-write shadow; a same-cycle write starts the next update.
          for (int i = 0; i < 5; i++) begin
            if (mask[i]) live[i] <= shadow[i];
          end
          commit_pulse <= 1'b1;
          mask         <= wr_bit;
          wait_cnt     <= '0;
          state        <= (|wr_bit) ? PENDING : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = live[0];
  assign en_reg_out_15_8 = live[1];
  assign en_reg_pwm_7_0  = live[2];
  assign en_reg_pwm_15_8 = live[3];
  assign pwm_duty_cycle  = live[4];
  assign pending         = |mask;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed table plus hand sequences for the pwm_update_scheduler with MAX_WAIT=16.
module tb_pwm_update_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       period_tick = 1'b0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       pending, commit_pulse, err_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  pwm_update_scheduler_if wr_if ();

  pwm_update_scheduler #(.MAX_WAIT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (wr_if.slave),
    .period_tick     (period_tick),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .pending         (pending),
    .commit_pulse    (commit_pulse),
    .err_addr        (err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        r;
    logic        v;
    logic [6:0]  a;
    logic [7:0]  d;
    logic        t;
    logic [39:0] live;
    logic        pend;
    logic        cp;
    logic        err;
  } vec_t;

  vec_t tbl [17];

  // Live bytes packed as {0x04, 0x03, 0x02, 0x01, 0x00}.
  function automatic logic [42:0] snap();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0,
            pending, commit_pulse, err_addr};
  endfunction

  task automatic chk(input string name, input logic [42:0] exp);
    logic [42:0] act;
    act = snap();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got live=%h pend=%b cp=%b err=%b, expected live=%h pend=%b cp=%b err=%b",
               name, act[42:3], act[2], act[1], act[0], exp[42:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [6:0] a, input logic [7:0] d,
                     input logic t);
    rst            = r;
    wr_if.wr_valid = v;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    period_tick    = t;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = 7'h00;
    wr_if.wr_data  = 8'h00;
    period_tick    = 1'b0;
    if (commit_pulse) pulse_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 7'h00, 8'h00, 1'b0);
    chk("reset_state", 43'h0);
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = 7'h00;
    wr_if.wr_data  = 8'h00;

    tbl[0]  = '{1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 40'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 40'h0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 40'h0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 40'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 7'h05, 8'h01, 1'b0, 40'h0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 7'h04, 8'h80, 1'b0, 40'h0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 7'h02, 8'hFF, 1'b0, 40'h0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 40'h0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 40'h0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 40'h80_00_FF_00_00, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 7'h10, 8'h55, 1'b0, 40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 7'h05, 8'h02, 1'b0, 40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 7'h06, 8'h01, 1'b0, 40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 7'h05, 8'h03, 1'b0, 40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].t);
      chk($sformatf("vec%0d", i), {tbl[i].live, tbl[i].pend, tbl[i].cp, tbl[i].err});
    end

    // Reset, then idle with period ticks: nothing may move.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 7'h00, 8'h00, (i % 8) == 0);
      chk($sformatf("idle%0d", i), 43'h0);
    end

    // Deferred commit, tick 10 cycles after the last write.
    pulse_cnt = 0;
    cyc(1'b0, 1'b1, 7'h04, 8'h80, 1'b0);
    chk("defer_pend", {40'h0, 1'b1, 1'b0, 1'b0});
    cyc(1'b0, 1'b1, 7'h02, 8'hFF, 1'b0);
    idle(9);
    chk("defer_wait", {40'h0, 1'b1, 1'b0, 1'b0});
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    chk("defer_m1", {40'h0, 1'b1, 1'b0, 1'b0});
    idle(1);
    chk("defer_m2", {40'h80_00_FF_00_00, 1'b0, 1'b1, 1'b0});
    idle(1);
    chk("defer_m3", {40'h80_00_FF_00_00, 1'b0, 1'b0, 1'b0});
    idle(3);
    n_cmp++;
    if (pulse_cnt != 1) begin
      n_bad++;
      $display("FAIL defer_pulses: got %0d expected 1", pulse_cnt);
    end

    // Timeout with MAX_WAIT=16: live visible 17 cycles after the cycle following the write.
    do_reset();
    cyc(1'b0, 1'b1, 7'h00, 8'h0F, 1'b0);
    idle(16);
    chk("tmo_early", {40'h0, 1'b1, 1'b0, 1'b0});
    idle(1);
    chk("tmo_commit", {40'h00_00_00_00_0F, 1'b0, 1'b1, 1'b0});

    // Forced commit via control register.
    cyc(1'b0, 1'b1, 7'h01, 8'hAA, 1'b0);
    cyc(1'b0, 1'b1, 7'h05, 8'h01, 1'b0);
    chk("force_m1", {40'h00_00_00_00_0F, 1'b1, 1'b0, 1'b0});
    idle(1);
    chk("force_m2", {40'h00_00_00_AA_0F, 1'b0, 1'b1, 1'b0});

    // Rewrite plus write on the tick cycle, then a write during COMMIT.
    cyc(1'b0, 1'b1, 7'h04, 8'h10, 1'b0);
    cyc(1'b0, 1'b1, 7'h04, 8'h40, 1'b1);
    chk("simul_m1", {40'h00_00_00_AA_0F, 1'b1, 1'b0, 1'b0});
    cyc(1'b0, 1'b1, 7'h04, 8'h20, 1'b0);
    chk("b2b_commit", {40'h40_00_00_AA_0F, 1'b1, 1'b1, 1'b0});
    idle(1);
    chk("b2b_hold", {40'h40_00_00_AA_0F, 1'b1, 1'b0, 1'b0});
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    chk("b2b_m1", {40'h40_00_00_AA_0F, 1'b1, 1'b0, 1'b0});
    idle(1);
    chk("b2b_second", {40'h20_00_00_AA_0F, 1'b0, 1'b1, 1'b0});

    // Reset while pending discards the update.
    cyc(1'b0, 1'b1, 7'h03, 8'h33, 1'b0);
    chk("rst_pend", {40'h20_00_00_AA_0F, 1'b1, 1'b0, 1'b0});
    cyc(1'b1, 1'b0, 7'h00, 8'h00, 1'b0);
    chk("rst_clear", 43'h0);
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    idle(1);
    chk("rst_notick", 43'h0);

    // Reset during the COMMIT cycle suppresses the commit.
    cyc(1'b0, 1'b1, 7'h00, 8'h01, 1'b0);
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 7'h00, 8'h00, 1'b0);
    chk("rst_commit", 43'h0);
    idle(2);
    chk("rst_commit_after", 43'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
